audio_sequencer: RTL

AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

---
 rtl/audio_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/audio_sequencer.sv
// Song player: walks {song, step} addresses through an external synchronous note ROM
// and holds each note for TICK_DIV clocks, with pause, loop and restart control.
module audio_sequencer #(
  parameter int NOTE_W   = 20,
  parameter int SEL_W    = 3,
  parameter int STEP_W   = 5,
  parameter int SONG_LEN = 32,
  parameter int TICK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     loop,
  input  logic [SEL_W-1:0]         sel,
  output logic [SEL_W+STEP_W-1:0]  rom_addr,
  input  logic [NOTE_W-1:0]        rom_data,
  output logic [NOTE_W-1:0]        note,
  output logic                     note_strobe,
  output logic [STEP_W-1:0]        step,
  output logic                     playing,
  output logic                     done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [NOTE_W-1:0] END_CODE  = '1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, PAUSE, DONE} state_t;

  state_t              state, state_n;
  logic [SEL_W-1:0]    song, song_n;
  logic [STEP_W-1:0]   step_n;
  logic [NOTE_W-1:0]   note_n;
  logic [TICK_W-1:0]   tick, tick_n;
  logic                strobe_n;
  logic                song_end;

  always_comb begin
    state_n  = state;
    song_n   = song;
    step_n   = step;
    note_n   = note;
    tick_n   = tick;
    strobe_n = 1'b0;
    song_end = 1'b0;
    if (stop || (start && sel == '0)) begin
      state_n = IDLE;
      step_n  = '0;
      note_n  = '0;
      tick_n  = '0;
    end else if (start) begin
      // Restart keeps the old note sounding until the new one arrives
      state_n = FETCH;
      song_n  = sel;
      step_n  = '0;
      tick_n  = '0;
    end else begin
      case (state)
        FETCH: state_n = WAIT;
        WAIT: begin
          if (rom_data == END_CODE) begin
            song_end = 1'b1;
          end else begin
            note_n   = rom_data;
            tick_n   = '0;
            strobe_n = 1'b1;
            state_n  = PLAY;
          end
        end
        PLAY, PAUSE: begin
          // Only cycles with pause high are frozen; the release edge counts as a tick
          if (pause) begin
            state_n = PAUSE;
          end else begin
            state_n = PLAY;
            if (tick == TICK_LAST) begin
              if (step == STEP_LAST) begin
                song_end = 1'b1;
              end else begin
                step_n  = step + STEP_W'(1);
                tick_n  = '0;
                state_n = FETCH;
              end
            end else begin
              tick_n = tick + TICK_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (song_end) begin
        if (loop) begin
          step_n  = '0;
          state_n = FETCH;
        end else begin
          note_n  = '0;
          state_n = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      song        <= '0;
      step        <= '0;
      note        <= '0;
      tick        <= '0;
      note_strobe <= 1'b0;
    end else begin
      state       <= state_n;
      song        <= song_n;
      step        <= step_n;
      note        <= note_n;
      tick        <= tick_n;
      note_strobe <= strobe_n;
    end
  end

  assign rom_addr = {song, step};
  assign playing  = (state == FETCH) || (state == WAIT) || (state == PLAY);
  assign done     = (state == DONE);

endmodule
